uart_rx: RTL

Serial receiver paired with the design's UART transmitter: it consumes the transmitter's idle-high serial line and returns parallel bytes. It uses the same baud-rate and parity selection codes and the same frame format: 1 start bit, 8 bits sent LSB-first, 1 stop bit. When parity is enabled, bit 7 of the frame carries parity instead of data. Each received byte is handed to a downstream consumer through a valid/ack handshake, with parity, framing and overrun status.

---
 rtl/uart_rx.sv | 174 +++++++++++++++++
 1 files changed

// File: rtl/uart_rx.sv
// UART receiver: 8N1/7+parity frames at a selectable baud rate, presented as bytes through a valid/ack handshake.
// Latency: byte valid one cycle after the stop-bit sample; no backpressure on the line, an unacked byte causes overrun.
module uart_rx #(
    parameter int unsigned CLKS_1200   = 8333,
    parameter int unsigned CLKS_2400   = 4167,
    parameter int unsigned CLKS_4800   = 2083,
    parameter int unsigned CLKS_9600   = 1042,
    parameter int unsigned CLKS_115200 = 87
) (
    input  logic       clkRx,
    input  logic       reset,
    input  logic       serialIn,
    input  logic [2:0] baudRateInput,
    input  logic [1:0] parityInput,
    input  logic       dataAck,
    output logic [7:0] dataOut,
    output logic       dataValid,
    output logic       parityError,
    output logic       frameError,
    output logic       overrun,
    output logic       busy
);

    localparam int CW = 16;

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] START = 2'd1;
    localparam logic [1:0] DATA  = 2'd2;
    localparam logic [1:0] STOP  = 2'd3;

    logic          rx_meta;
    logic          rxs;
    logic [1:0]    state;
    logic [CW-1:0] cpb;
    logic [CW-1:0] half_cpb;
    logic [CW-1:0] clk_count;
    logic [2:0]    bit_index;
    logic [7:0]    shift;
    logic [1:0]    par_mode;
    logic          done;
    logic [7:0]    res_data;
    logic          res_perr;
    logic          res_ferr;
    logic [CW-1:0] cpb_sel;
    logic          cpb_sel_ok;

    assign half_cpb = (cpb - CW'(1)) >> 1;
    assign busy     = (state != IDLE);

    always_ff @(posedge clkRx or negedge reset) begin
        if (!reset) begin
            rx_meta <= 1'b1;
            rxs     <= 1'b1;
        end else begin
            rx_meta <= serialIn;
            rxs     <= rx_meta;
        end
    end

    always_comb begin
        cpb_sel    = CW'(CLKS_9600);
        cpb_sel_ok = 1'b1;
        case (baudRateInput)
            3'd0:    cpb_sel = CW'(CLKS_1200);
            3'd1:    cpb_sel = CW'(CLKS_2400);
            3'd2:    cpb_sel = CW'(CLKS_4800);
            3'd3:    cpb_sel = CW'(CLKS_9600);
            3'd4:    cpb_sel = CW'(CLKS_115200);
            default: cpb_sel_ok = 1'b0;
        endcase
    end

    always_ff @(posedge clkRx or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            cpb       <= CW'(CLKS_9600);
            clk_count <= '0;
            bit_index <= '0;
            shift     <= '0;
            par_mode  <= '0;
            done      <= 1'b0;
            res_data  <= '0;
            res_perr  <= 1'b0;
            res_ferr  <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    clk_count <= '0;
                    bit_index <= '0;
                    if (cpb_sel_ok) cpb <= cpb_sel;
                    if (!rxs) begin
                        state    <= START;
                        par_mode <= parityInput;
                    end
                end
                START: begin
                    if (clk_count == half_cpb) begin
                        clk_count <= '0;
                        state     <= rxs ? IDLE : DATA;
                    end else begin
                        clk_count <= clk_count + CW'(1);
                    end
                end
                DATA: begin
                    if (clk_count == cpb - CW'(1)) begin
                        shift[bit_index] <= rxs;
                        clk_count        <= '0;
                        if (bit_index == 3'd7) begin
                            state <= STOP;
                        end else begin
                            bit_index <= bit_index + 3'd1;
                        end
                    end else begin
                        clk_count <= clk_count + CW'(1);
                    end
                end
                default: begin
                    // Return to IDLE mid-stop-bit so a back-to-back start edge is not missed.
                    if (clk_count == cpb - CW'(1)) begin
                        state     <= IDLE;
                        clk_count <= '0;
                        done      <= 1'b1;
                        res_ferr  <= ~rxs;
                        case (par_mode)
                            2'd1: begin
                                res_data <= {1'b0, shift[6:0]};
                                res_perr <= (shift[7] != (^shift[6:0]));
                            end
                            2'd2: begin
                                res_data <= {1'b0, shift[6:0]};
                                res_perr <= (shift[7] != (~^shift[6:0]));
                            end
                            default: begin
                                res_data <= shift;
                                res_perr <= 1'b0;
                            end
                        endcase
                    end else begin
                        clk_count <= clk_count + CW'(1);
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clkRx or negedge reset) begin
        if (!reset) begin
            dataOut     <= '0;
            dataValid   <= 1'b0;
            parityError <= 1'b0;
            frameError  <= 1'b0;
            overrun     <= 1'b0;
        end else begin
            if (done) begin
                if (!dataValid || dataAck) begin
                    dataOut     <= res_data;
                    parityError <= res_perr;
                    frameError  <= res_ferr;
                    dataValid   <= 1'b1;
                end
            end else if (dataAck) begin
                dataValid <= 1'b0;
            end

            if (done && dataValid && !dataAck) begin
                overrun <= 1'b1;
            end else if (dataAck) begin
                overrun <= 1'b0;
            end
        end
    end

endmodule
